// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence-detector benches.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam int                   SEQ_PAT_W    = 5;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN  = 5'b10010;
    localparam logic                 SEQ_IDLE_BIT = 1'b0;

endpackage

// File: rtl/pattern_shreg.sv
// Parallel-load shift register, MSB out. Shifting back-fills with the idle level so the
// line settles to IDLE_BIT once the last pattern bit has left.
module pattern_shreg
    import seq_pkg::*;
#(
    parameter int   PAT_W    = SEQ_PAT_W,
    parameter logic IDLE_BIT = SEQ_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb
);

    logic [PAT_W-1:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= {PAT_W{IDLE_BIT}};
        end else if (load) begin
            data <= load_val;
        end else if (shift) begin
            data <= {data[PAT_W-2:0], IDLE_BIT};
        end
    end

    assign msb = data[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first for repeat_n+1 frames, with an
// optional idle gap between frames. j comes straight from the shift register flop.
//
//   state | meaning
//   IDLE  | line idle, waiting for start
//   SEND  | pattern bit bit_cnt of frame frame_idx is on the line
//   GAP   | idle cycles between frames, gap_cnt counts down to 0
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W    = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN  = SEQ_PATTERN,
    parameter int               CNT_W    = 4,
    parameter int               GAP_LEN  = 0,
    parameter logic             IDLE_BIT = SEQ_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             j,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_idx
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    seq_state_t        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  rep;

    logic start_ok, last_bit, more, gap_end;
    logic ld_pat, ld_idle, sh_en;

    assign start_ok = (state == IDLE) && start && !abort;
    assign last_bit = (state == SEND) && (bit_cnt == BIT_W'(PAT_W - 1));
    assign more     = (frame_idx != rep);
    assign gap_end  = (state == GAP) && (gap_cnt == '0);

    // Reload instead of shifting when the next frame follows without a gap.
    assign ld_pat  = start_ok ||
                     (!abort && gap_end) ||
                     (!abort && last_bit && more && (GAP_LEN == 0));
    assign ld_idle = abort && (state != IDLE);
    assign sh_en   = (state == SEND) && !abort && !ld_pat;

    pattern_shreg #(
        .PAT_W    (PAT_W),
        .IDLE_BIT (IDLE_BIT)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (ld_pat || ld_idle),
        .shift    (sh_en),
        .load_val (ld_idle ? {PAT_W{IDLE_BIT}} : PATTERN),
        .msb      (j)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            rep       <= '0;
            frame_idx <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                frame_idx <= '0;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state     <= SEND;
                            bit_cnt   <= '0;
                            frame_idx <= '0;
                            rep       <= repeat_n;
                            bit_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (!more) begin
                            state     <= IDLE;
                            bit_cnt   <= '0;
                            bit_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP_LEN == 0) begin
                            bit_cnt   <= '0;
                            frame_idx <= frame_idx + 1'b1;
                        end else begin
                            state     <= GAP;
                            bit_cnt   <= '0;
                            gap_cnt   <= GAP_W'(GAP_LEN - 1);
                            bit_valid <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state     <= SEND;
                            frame_idx <= frame_idx + 1'b1;
                            bit_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance back-to-back (GAP_LEN=0), one with
// a 3-cycle inter-frame gap; both share the same stimulus.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] repeat_n = '0;

    logic       j0, bv0, busy0, done0;
    logic [3:0] fidx0;
    logic       j3, bv3, busy3, done3;
    logic [3:0] fidx3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.GAP_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .abort(abort),
        .j(j0), .bit_valid(bv0), .busy(busy0), .done(done0), .frame_idx(fidx0)
    );

    seq_pattern_tx #(.GAP_LEN(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .abort(abort),
        .j(j3), .bit_valid(bv3), .busy(busy3), .done(done3), .frame_idx(fidx3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checks one 10010 frame on dut0, starting in the first bit cycle; ends in the cycle after.
    task automatic frame0(input string tag, input logic [3:0] fidx);
        logic [4:0] pat;
        pat = 5'b10010;
        for (int k = 0; k < 5; k++) begin
            chk({tag, " j"}, 32'(j0), 32'(pat[4-k]));
            chk({tag, " bit_valid"}, 32'(bv0), 32'd1);
            chk({tag, " busy"}, 32'(busy0), 32'd1);
            chk({tag, " done"}, 32'(done0), 32'd0);
            chk({tag, " frame_idx"}, 32'(fidx0), 32'(fidx));
            cyc();
        end
    endtask

    task automatic pulse_start(input logic [3:0] rn);
        repeat_n = rn;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    initial begin
        logic [20:0] exp_j;
        logic [20:0] exp_v;
        logic [4:0]  win;
        int          hits;

        cyc(2);
        chk("reset j", 32'(j0), 32'd0);
        chk("reset bit_valid", 32'(bv0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset done", 32'(done0), 32'd0);
        chk("reset frame_idx", 32'(fidx0), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Single frame.
        pulse_start(4'd0);
        frame0("single", 4'd0);
        chk("single done", 32'(done0), 32'd1);
        chk("single busy at done", 32'(busy0), 32'd0);
        chk("single bit_valid at done", 32'(bv0), 32'd0);
        chk("single j at done", 32'(j0), 32'd0);
        cyc();
        chk("single done one cycle", 32'(done0), 32'd0);
        cyc(3);

        // Two frames back-to-back, with a sliding-window detector count.
        pulse_start(4'd1);
        win  = '0;
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            chk("b2b j", 32'(j0), 32'((10'b1001010010 >> (9 - k)) & 1));
            chk("b2b frame_idx", 32'(fidx0), (k < 5) ? 32'd0 : 32'd1);
            chk("b2b bit_valid", 32'(bv0), 32'd1);
            win = {win[3:0], j0};
            if (win == 5'b10010) hits++;
            cyc();
        end
        chk("b2b detections", 32'(hits), 32'd2);
        chk("b2b done", 32'(done0), 32'd1);
        cyc(20);

        // Three frames with 3-cycle gaps on dut3.
        exp_j = 21'b100100001001000010010;
        exp_v = 21'b111110001111100011111;
        pulse_start(4'd2);
        for (int k = 0; k < 21; k++) begin
            chk("gap j", 32'(j3), 32'(exp_j[20-k]));
            chk("gap bit_valid", 32'(bv3), 32'(exp_v[20-k]));
            chk("gap busy", 32'(busy3), 32'd1);
            chk("gap done", 32'(done3), 32'd0);
            chk("gap frame_idx", 32'(fidx3), (k < 8) ? 32'd0 : ((k < 16) ? 32'd1 : 32'd2));
            cyc();
        end
        chk("gap final done", 32'(done3), 32'd1);
        chk("gap busy at done", 32'(busy3), 32'd0);
        cyc();
        chk("gap done one cycle", 32'(done3), 32'd0);
        cyc(5);

        // start while busy is ignored; start on the done cycle is accepted.
        pulse_start(4'd0);
        chk("busy-start bit0", 32'(j0), 32'd1);
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy-start bit2", 32'(j0), 32'd0);
        cyc();
        chk("busy-start bit3", 32'(j0), 32'd1);
        cyc();
        chk("busy-start bit4", 32'(j0), 32'd0);
        cyc();
        chk("busy-start done", 32'(done0), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        frame0("restart", 4'd0);
        chk("restart done", 32'(done0), 32'd1);
        cyc();
        chk("restart no requeue", 32'(busy0), 32'd0);
        cyc(3);

        // Abort in cycle 3 of frame 0.
        pulse_start(4'd3);
        cyc(2);
        chk("abort pre busy", 32'(busy0), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort j", 32'(j0), 32'd0);
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort bit_valid", 32'(bv0), 32'd0);
        chk("abort frame_idx", 32'(fidx0), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("abort no done", 32'(done0), 32'd0);
            chk("abort stays idle", 32'(busy0), 32'd0);
            cyc();
        end

        // abort together with start in IDLE.
        abort = 1'b1;
        pulse_start(4'd0);
        abort = 1'b0;
        chk("abort+start busy", 32'(busy0), 32'd0);
        chk("abort+start bit_valid", 32'(bv0), 32'd0);
        cyc(2);

        // Asynchronous reset between edges.
        pulse_start(4'd1);
        chk("pre-rst j", 32'(j0), 32'd1);
        chk("pre-rst busy", 32'(busy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst j", 32'(j0), 32'd0);
        chk("async rst busy", 32'(busy0), 32'd0);
        chk("async rst bit_valid", 32'(bv0), 32'd0);
        chk("async rst frame_idx", 32'(fidx0), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        pulse_start(4'd0);
        frame0("post-rst", 4'd0);
        chk("post-rst done", 32'(done0), 32'd1);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the generator side of the serial sequence-detector path. On a start request it shifts a fixed PAT_W-bit pattern (default 10010) out MSB-first on the 1-bit line j, one bit per clock, for a programmable number of frames, with an optional idle gap between frames. It drives the j input of the moore10010/mealy10010 detectors in the detector test environment and provides busy/done status to a controlling sequencer.

Parameters:
PAT_W, 5, pattern length in bits (>=2)
PATTERN, 5'b10010, bit pattern, transmitted MSB first
CNT_W, 4, width of frame-repeat field
GAP_LEN, 0, idle cycles inserted between consecutive frames (0 = back-to-back)
IDLE_BIT, 1'b0, value driven on j when not transmitting

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request transmission; sampled only in IDLE
repeat_n  in  CNT_W  extra frames after the first; latched with start (0 = one frame)
abort  in  1  synchronous cancel, highest priority after rst
j  out  1  serial data line, registered
bit_valid  out  1  high while j carries a pattern bit, registered
busy  out  1  high from cycle after accepted start until done/abort
done  out  1  one-cycle pulse after last bit of last frame
frame_idx  out  CNT_W  index of frame currently on the line (0-based)

Behaviour:
- One clock; reset asynchronous and active-high: clk and rst.
- Reset values: j=IDLE_BIT, bit_valid=0, busy=0, done=0, frame_idx=0, state=IDLE, bit counter=0, repeat register=0.
- FSM states: IDLE, SEND, GAP.
- IDLE: start=1 at edge t -> latch repeat_n, go SEND. Cycle t+1: j=PATTERN[PAT_W-1], bit_valid=1, busy=1. Latency start->first bit = 1 cycle.
- SEND: bit k (k=0..PAT_W-1) = PATTERN[PAT_W-1-k] in cycle t+1+k; bit counter increments each cycle.
- After last bit of a frame:
  - frames remain and GAP_LEN>0 -> GAP.
  - frames remain and GAP_LEN=0 -> next frame's MSB in the immediately following cycle; frame_idx increments in that cycle.
  - none remain -> IDLE; in the following cycle done=1, busy=0, bit_valid=0, j=IDLE_BIT.
- GAP: exactly GAP_LEN cycles with j=IDLE_BIT, bit_valid=0, busy=1; then SEND with frame_idx+1.
- Total frames = repeat_n+1. Internal frame counter is CNT_W bits; no wrap because the maximum index equals repeat_n.
- start while busy: ignored, no queuing. start in the cycle done is high: accepted, because the FSM is already in IDLE.
- abort=1 at any edge while busy: next cycle IDLE, j=IDLE_BIT, bit_valid=0, busy=0, done stays 0, frame_idx=0. abort together with start in IDLE: start ignored.
- rst mid-frame: outputs go to reset values immediately (asynchronous); the partial frame is discarded.
- done is never asserted for more than one cycle. busy and done are never high together.

Decomposition:
- Shared package seq_pkg: state enum (IDLE/SEND/GAP), default PATTERN and PAT_W constants shared with the detector benches, and IDLE_BIT.
- One natural sub-module, pattern_shreg: parallel-load PAT_W shift register with load/shift enables, MSB out. The FSM and counters stay in seq_pattern_tx.

Test Plan:
- Reset then start=1 for one cycle, repeat_n=0 -> j=1,0,0,1,0 on cycles 1-5, bit_valid=1 on cycles 1-5, done=1 on cycle 6 only, busy=0 from cycle 6.
- repeat_n=1, GAP_LEN=0 -> j=1001010010 over 10 cycles, frame_idx 0 for cycles 1-5 and 1 for cycles 6-10. Looped into mealy10010 and moore10010: exactly 2 detections each, in consistent cycles.
- repeat_n=2, GAP_LEN=3 -> 10010 000 10010 000 10010, bit_valid low only during gaps, single done after cycle 21.
- start pulsed again at cycle 3 of a frame -> ignored; output identical to the single-frame case. start on the done cycle -> new frame begins the next cycle.
- abort at cycle 3 of frame 0 (repeat_n=3) -> from cycle 4 j=0, busy=0, bit_valid=0, no done pulse, frame_idx=0.
- rst asserted asynchronously mid-bit (between edges) -> j, busy and bit_valid drop before the next edge. After release, a fresh start produces the full pattern.
